// File: rtl/mips_dmem_arbiter_pkg.sv
// Shared types and helpers for the MIPS data-memory arbiter.
package mips_dmem_arbiter_pkg;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  function automatic logic in_range(input logic [63:0] addr, input int unsigned depth);
    return addr < 64'(depth);
  endfunction

endpackage

// File: rtl/mips_rr_picker.sv
// Two-way round-robin chooser: on contention the port not named by rr_ptr wins.
module mips_rr_picker
  import mips_dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic valid,
  output logic sel,
  output logic next_ptr
);

  always_comb begin
    valid    = req0 | req1;
    sel      = PORT0;
    next_ptr = rr_ptr;
    if (req0 && req1) begin
      sel      = ~rr_ptr;
      next_ptr = ~rr_ptr;
    end else if (req1) begin
      sel = PORT1;
    end
  end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU (port 0) and a
// burst-capable DMA/debug master (port 1), with bounded CPU wait during bursts.
module mips_dmem_arbiter
  import mips_dmem_arbiter_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 100,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [Width-1:0] m0_addr,
  input  logic [Width-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [Width-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [Width-1:0] m1_addr,
  input  logic [7:0]       m1_len,
  input  logic [Width-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [Width-1:0] m1_rdata,
  output logic             m1_done,
  output logic             err,
  output logic             mem_we,
  output logic [Width-1:0] mem_a,
  output logic [Width-1:0] mem_wd,
  input  logic [Width-1:0] mem_rd
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  arb_state_t       state, state_n;
  logic             rr_ptr, rr_ptr_n;
  logic [7:0]       beats_left, beats_left_n;
  logic [Width-1:0] burst_addr, burst_addr_n;
  logic             burst_we, burst_we_n;
  logic [WW-1:0]    wait_cnt, wait_cnt_n;
  logic             done_n;
  logic             g0, g1, we_sel, inr;
  logic             pick_valid, pick_sel, pick_next;

  function automatic logic [Width-1:0] next_addr(input logic [Width-1:0] a);
    return (a == Width'(Depth - 1)) ? '0 : a + Width'(1);
  endfunction

  mips_rr_picker u_picker (
    .req0    (m0_req),
    .req1    (m1_req),
    .rr_ptr  (rr_ptr),
    .valid   (pick_valid),
    .sel     (pick_sel),
    .next_ptr(pick_next)
  );

  always_comb begin
    state_n      = state;
    rr_ptr_n     = rr_ptr;
    beats_left_n = beats_left;
    burst_addr_n = burst_addr;
    burst_we_n   = burst_we;
    wait_cnt_n   = wait_cnt;
    done_n       = 1'b0;
    g0           = 1'b0;
    g1           = 1'b0;
    we_sel       = 1'b0;
    mem_a        = '0;
    mem_wd       = '0;
    mem_we       = 1'b0;
    inr          = 1'b1;

    // No grants while reset is asserted, so an aborted burst cannot write.
    if (rst) begin
      case (state)
        S_IDLE: begin
          wait_cnt_n = '0;
          if (pick_valid) begin
            rr_ptr_n = pick_next;
            if (pick_sel == PORT0) begin
              g0 = 1'b1;
            end else begin
              g1           = 1'b1;
              beats_left_n = (m1_len == 8'd0) ? 8'd0 : m1_len - 8'd1;
              burst_addr_n = next_addr(m1_addr);
              burst_we_n   = m1_we;
              if (beats_left_n != 8'd0) state_n = S_BURST;
              else                      done_n  = 1'b1;
            end
          end
        end
        S_BURST: begin
          if (m0_req && wait_cnt == WW'(MAX_WAIT)) begin
            g0         = 1'b1;
            wait_cnt_n = '0;
          end else begin
            g1           = 1'b1;
            beats_left_n = beats_left - 8'd1;
            burst_addr_n = next_addr(burst_addr);
            if (m0_req) wait_cnt_n = wait_cnt + WW'(1);
            if (beats_left == 8'd1) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    if (g0) begin
      mem_a  = m0_addr;
      mem_wd = m0_wdata;
      we_sel = m0_we;
    end else if (g1) begin
      mem_a  = (state == S_IDLE) ? m1_addr : burst_addr;
      mem_wd = m1_wdata;
      we_sel = (state == S_IDLE) ? m1_we : burst_we;
    end
    inr    = in_range(64'(mem_a), Depth);
    mem_we = (g0 | g1) & we_sel & inr;
  end

  assign m0_gnt = g0;
  assign m1_gnt = g1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      rr_ptr     <= PORT0;
      beats_left <= '0;
      burst_addr <= '0;
      burst_we   <= 1'b0;
      wait_cnt   <= '0;
      m0_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rvalid  <= 1'b0;
      m1_rdata   <= '0;
      m1_done    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      beats_left <= beats_left_n;
      burst_addr <= burst_addr_n;
      burst_we   <= burst_we_n;
      wait_cnt   <= wait_cnt_n;
      m0_rvalid  <= g0 & ~we_sel;
      m1_rvalid  <= g1 & ~we_sel;
      if (g0 && !we_sel) m0_rdata <= inr ? mem_rd : '0;
      if (g1 && !we_sel) m1_rdata <= inr ? mem_rd : '0;
      m1_done    <= done_n;
      err        <= (g0 | g1) & ~inr;
    end
  end

endmodule
